float_accumulate_sequencer: RTL and testbench

Initiator-side controller that sits in front of the floating-point adder and drives its operand interface. It accepts a stream of single-precision `float` elements grouped into packets, and feeds the running sum and the next element to the adder. It waits for the adder's `ResultValid`, folds the adder result back into the accumulator, and emits one `float` sum per packet. It owns the adder handshake timing, so upstream producers never touch `InputValid`/`ResultValid` directly.

---
 rtl/float_accumulate_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_float_accumulate_sequencer.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_accumulate_sequencer.sv
// float_accumulate_sequencer
// Drives the operand side of an external floating-point adder so that a
// packet of float elements is reduced to one float sum. The block never
// does float arithmetic itself: values are moved bit-exact between the
// input stream, the accumulator, the adder operands and the sum output.
module float_accumulate_sequencer #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [31:0]      InData,
   input  logic             InValid,
   input  logic             InLast,
   output logic             InReady,
   output logic [31:0]      Op1,
   output logic [31:0]      Op2,
   output logic             AddValid,
   input  logic [31:0]      AddResult,
   input  logic             AddResultValid,
   output logic [31:0]      Sum,
   output logic             SumValid,
   output logic [CNT_W-1:0] SumCount,
   output logic             Error
);

   localparam int               TMR_W    = $clog2(TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_CLEAR = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [31:0]      r_acc;
   logic             r_acc_empty;
   logic             r_last_pend;
   logic [CNT_W-1:0] r_cnt;
   logic [TMR_W-1:0] r_timer;
   logic [31:0]      r_op1;
   logic [31:0]      r_op2;
   logic [31:0]      r_sum;
   logic [CNT_W-1:0] r_sum_cnt;
   logic             r_error;

   logic             w_in_ready;
   logic             w_add_valid;
   logic             w_sum_valid;
   logic             w_load_first;
   logic             w_load_ops;
   logic             w_take_result;
   logic             w_timeout;
   logic             w_timer_clr;
   logic             w_timer_inc;
   logic             w_sum_load;

   // Element counter saturates at all-ones; the sum keeps accumulating.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   // State register
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state decode and per-state strobes for the datapath registers
   always_comb begin
      w_state_nxt   = r_state;
      w_in_ready    = 1'b0;
      w_add_valid   = 1'b0;
      w_sum_valid   = 1'b0;
      w_load_first  = 1'b0;
      w_load_ops    = 1'b0;
      w_take_result = 1'b0;
      w_timeout     = 1'b0;
      w_timer_clr   = 1'b0;
      w_timer_inc   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_in_ready = 1'b1;
            if (InValid) begin
               if (r_acc_empty) begin
                  // First element of a packet seeds the accumulator directly.
                  w_load_first = 1'b1;
                  if (InLast) w_state_nxt = S_DONE;
               end else begin
                  w_load_ops  = 1'b1;
                  w_state_nxt = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            w_add_valid = 1'b1;
            w_state_nxt = S_CLEAR;
         end
         S_CLEAR: begin
            // Result-valid still reflects the previous operation here.
            w_timer_clr = 1'b1;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (AddResultValid) begin
               w_take_result = 1'b1;
               w_state_nxt   = r_last_pend ? S_DONE : S_IDLE;
            end else if (r_timer == TMR_LAST) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_timer_inc = 1'b1;
            end
         end
         S_DONE: begin
            w_sum_valid = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Sum registers load on entry to DONE so they line up with the SumValid pulse.
   assign w_sum_load = (w_load_first && InLast) || (w_take_result && r_last_pend);

   // Accumulator, element count and empty flag
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_acc       <= '0;
         r_acc_empty <= 1'b1;
         r_cnt       <= '0;
      end else begin
         if (w_load_first) begin
            r_acc       <= InData;
            r_cnt       <= CNT_W'(1);
            r_acc_empty <= 1'b0;
         end else if (w_load_ops) begin
            r_cnt <= sat_inc(r_cnt);
         end else if (w_take_result) begin
            r_acc <= AddResult;
         end else if (w_timeout) begin
            // Aborted packet: the next element starts a fresh sum.
            r_acc_empty <= 1'b1;
            r_cnt       <= '0;
         end else if (r_state == S_DONE) begin
            r_acc_empty <= 1'b1;
         end
      end
   end

   // Adder operands and last-element flag, captured only on an accept into ISSUE
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_op1       <= '0;
         r_op2       <= '0;
         r_last_pend <= 1'b0;
      end else if (w_load_ops) begin
         r_op1       <= r_acc;
         r_op2       <= InData;
         r_last_pend <= InLast;
      end
   end

   // Wait-cycle timer for adder hang detection
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_timer <= '0;
      end else if (w_timer_clr) begin
         r_timer <= '0;
      end else if (w_timer_inc) begin
         r_timer <= r_timer + TMR_W'(1);
      end
   end

   // Reported sum and count, held until the next packet completes
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_sum     <= '0;
         r_sum_cnt <= '0;
      end else if (w_sum_load) begin
         r_sum     <= w_load_first ? InData : AddResult;
         r_sum_cnt <= w_load_first ? CNT_W'(1) : r_cnt;
      end
   end

   // Sticky error flag, set when the adder never answers
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset)         r_error <= 1'b0;
      else if (w_timeout) r_error <= 1'b1;
   end

   assign InReady  = w_in_ready;
   assign AddValid = w_add_valid;
   assign SumValid = w_sum_valid;
   assign Op1      = r_op1;
   assign Op2      = r_op2;
   assign Sum      = r_sum;
   assign SumCount = r_sum_cnt;
   assign Error    = r_error;

endmodule

// File: tb/tb_float_accumulate_sequencer.sv
// Testbench for float_accumulate_sequencer: a behavioural adder plus a
// packet-level reference (real-valued sums) checked on every cycle.
`timescale 1ns/1ps
module tb_float_accumulate_sequencer;

   localparam int TIMEOUT = 12;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             Clock = 1'b0;
   logic             Reset;
   logic [31:0]      InData;
   logic             InValid;
   logic             InLast;
   logic             InReady;
   logic [31:0]      Op1;
   logic [31:0]      Op2;
   logic             AddValid;
   logic [31:0]      AddResult;
   logic             AddResultValid;
   logic [31:0]      Sum;
   logic             SumValid;
   logic [CNT_W-1:0] SumCount;
   logic             Error;

   float_accumulate_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .Clock(Clock), .Reset(Reset),
      .InData(InData), .InValid(InValid), .InLast(InLast), .InReady(InReady),
      .Op1(Op1), .Op2(Op2), .AddValid(AddValid),
      .AddResult(AddResult), .AddResultValid(AddResultValid),
      .Sum(Sum), .SumValid(SumValid), .SumCount(SumCount), .Error(Error)
   );

   always #5 Clock = ~Clock;

   int n_cmp = 0;
   int n_err = 0;

   // Reference queues filled from the intended packets
   logic [31:0] exp_sum_q[$];
   int          exp_cnt_q[$];
   logic [31:0] exp_op1_q[$];
   logic [31:0] exp_op2_q[$];
   bit          exp_last_q[$];
   real         pkt_q[$];

   // Adder model / monitor state
   bit          stale_mode = 1'b0;
   bit          hang_mode  = 1'b0;
   int          cyc = 0;
   bit          pend = 1'b0, busy = 1'b0, chk_on = 1'b0;
   bit          cur_last = 1'b0, chk_last = 1'b0;
   bit          prev_av = 1'b0, prev_sv = 1'b0;
   int          res_cyc = -1, clr_cyc = -1, busy_end = -1, chk_cyc = -1;
   logic [31:0] op_a, op_b;
   int          add_pulses = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Exact for the integer and half-integer values used here.
   function automatic logic [31:0] r2f(input real r);
      logic [63:0] b;
      logic [10:0] e;
      if (r == 0.0) return 32'h0;
      b = $realtobits(r);
      e = b[62:52];
      return {b[63], 8'(e - 11'd896), b[51:29]};
   endfunction

   function automatic real f2r(input logic [31:0] f);
      logic [63:0] b;
      if (f[30:0] == 31'h0) return 0.0;
      b = {f[31], 11'({3'b000, f[30:23]} + 11'd896), f[22:0], 29'h0};
      return $bitstoreal(b);
   endfunction

   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
      return r2f(f2r(a) + f2r(b));
   endfunction

   // Adder model and per-cycle compare process
   initial begin
      int          lat;
      logic [31:0] e1, e2;
      AddResultValid = 1'b0;
      AddResult      = 32'h0;
      forever begin
         @(negedge Clock);
         cyc++;
         if (Reset === 1'b1) begin
            if (pend && cyc == res_cyc) begin
               AddResultValid = 1'b1;
               AddResult      = fadd(op_a, op_b);
               pend           = 1'b0;
               chk_on         = 1'b1;
               chk_cyc        = cyc + 1;
               chk_last       = cur_last;
            end else if (cyc == clr_cyc) begin
               AddResultValid = 1'b0;
            end
            if (chk_on && cyc == chk_cyc) begin
               chk("sumvalid_after_result", 64'(SumValid), 64'(chk_last));
               chk("ready_after_result", 64'(InReady), 64'(!chk_last));
               chk_on = 1'b0;
            end
            if (busy) begin
               chk("ready_low_while_busy", 64'(InReady), 64'(0));
               if (cyc >= busy_end) busy = 1'b0;
            end
            if (AddValid) begin
               add_pulses++;
               chk("addvalid_back_to_back", 64'(prev_av), 64'(0));
               chk("addvalid_while_busy", 64'(busy), 64'(0));
               chk("ready_in_issue", 64'(InReady), 64'(0));
               if (exp_op1_q.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL unexpected_issue: AddValid=1 with Op1=0x%0h, required no issue", Op1);
               end else begin
                  e1 = exp_op1_q.pop_front();
                  e2 = exp_op2_q.pop_front();
                  cur_last = exp_last_q.pop_front();
                  chk("op1", 64'(Op1), 64'(e1));
                  chk("op2", 64'(Op2), 64'(e2));
               end
               op_a    = Op1;
               op_b    = Op2;
               clr_cyc = cyc + (stale_mode ? 2 : 1);
               lat     = stale_mode ? int'($urandom_range(3, 5)) : int'($urandom_range(2, 5));
               if (hang_mode) begin
                  pend     = 1'b0;
                  busy_end = cyc + 1 + TIMEOUT;
               end else begin
                  pend     = 1'b1;
                  res_cyc  = cyc + lat;
                  busy_end = res_cyc;
               end
               busy = 1'b1;
            end
            if (SumValid) begin
               if (exp_sum_q.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL unexpected_sum: SumValid=1 Sum=0x%0h, required no sum", Sum);
               end else begin
                  chk("sum", 64'(Sum), 64'(exp_sum_q.pop_front()));
                  chk("sum_count", 64'(SumCount), 64'(exp_cnt_q.pop_front()));
               end
            end
            chk("sumvalid_pulse", 64'(prev_sv && SumValid), 64'(0));
            prev_av = AddValid;
            prev_sv = SumValid;
         end else begin
            prev_av = 1'b0;
            prev_sv = 1'b0;
         end
      end
   end

   // Drives pkt_q as one packet; junk=1 toggles InData/InLast while not ready.
   task automatic send_packet(input bit junk, input bit abort);
      real part;
      int  n;
      int  guard;
      n    = pkt_q.size();
      part = pkt_q[0];
      for (int i = 1; i < n; i++) begin
         exp_op1_q.push_back(r2f(part));
         exp_op2_q.push_back(r2f(pkt_q[i]));
         exp_last_q.push_back(i == n - 1);
         part += pkt_q[i];
      end
      if (!abort) begin
         exp_sum_q.push_back(r2f(part));
         exp_cnt_q.push_back(n > CNT_MAX ? CNT_MAX : n);
      end
      for (int i = 0; i < n; i++) begin
         guard = 0;
         while (InReady !== 1'b1) begin
            if (junk) begin
               InValid = 1'b1;
               InData  = $urandom;
               InLast  = 1'($urandom);
            end else begin
               InValid = 1'b0;
            end
            @(negedge Clock);
            guard++;
            if (guard > 200) begin
               n_cmp++; n_err++;
               $display("FAIL ready_timeout: InReady=0 for %0d cycles, required 1", guard);
               InValid = 1'b0;
               return;
            end
         end
         InValid = 1'b1;
         InData  = r2f(pkt_q[i]);
         InLast  = (i == n - 1);
         @(negedge Clock);
         InValid = 1'b0;
         if (i == 0 && n == 1) chk("single_sumvalid_next_cycle", 64'(SumValid), 64'(1));
         else if (i == 0)      chk("ready_after_first", 64'(InReady), 64'(1));
         else                  chk("addvalid_next_cycle", 64'(AddValid), 64'(1));
      end
      InValid = 1'b0;
   endtask

   task automatic wait_idle();
      int g;
      g = 0;
      while (!(exp_sum_q.size() == 0 && InReady === 1'b1 && !busy && !chk_on)) begin
         @(negedge Clock);
         g++;
         if (g > 400) begin
            n_cmp++; n_err++;
            $display("FAIL idle_timeout: %0d sums outstanding after %0d cycles, required 0", exp_sum_q.size(), g);
            return;
         end
      end
      @(negedge Clock);
   endtask

   initial begin
      int a0;
      Reset   = 1'b0;
      InValid = 1'b0;
      InData  = 32'h0;
      InLast  = 1'b0;

      // Pin the reference model with hand-computed encodings
      chk("model_1.0", 64'(r2f(1.0)), 64'h3F800000);
      chk("model_6.0", 64'(r2f(6.0)), 64'h40C00000);
      chk("model_-2.0", 64'(r2f(-2.0)), 64'hC0000000);
      chk("model_add_0.5_0.5", 64'(fadd(32'h3F000000, 32'h3F000000)), 64'h3F800000);
      chk("model_add_1_2", 64'(fadd(32'h3F800000, 32'h40000000)), 64'h40400000);

      repeat (2) @(negedge Clock);
      chk("rst_op1", 64'(Op1), 64'(0));
      chk("rst_op2", 64'(Op2), 64'(0));
      chk("rst_sum", 64'(Sum), 64'(0));
      chk("rst_sumcount", 64'(SumCount), 64'(0));
      chk("rst_addvalid", 64'(AddValid), 64'(0));
      chk("rst_sumvalid", 64'(SumValid), 64'(0));
      chk("rst_error", 64'(Error), 64'(0));
      Reset = 1'b1;
      @(negedge Clock);
      chk("ready_after_reset", 64'(InReady), 64'(1));

      // Single-element packet bypasses the adder
      a0 = add_pulses;
      pkt_q = '{1.0};
      send_packet(1'b0, 1'b0);
      wait_idle();
      chk("single_sum", 64'(Sum), 64'h3F800000);
      chk("single_count", 64'(SumCount), 64'(1));
      chk("single_no_add", 64'(add_pulses - a0), 64'(0));

      // 1 + 2 + 3
      a0 = add_pulses;
      pkt_q = '{1.0, 2.0, 3.0};
      send_packet(1'b0, 1'b0);
      wait_idle();
      chk("sum_123", 64'(Sum), 64'h40C00000);
      chk("count_123", 64'(SumCount), 64'(3));
      chk("adds_123", 64'(add_pulses - a0), 64'(2));

      // Stale result-valid held high through CLEAR
      stale_mode = 1'b1;
      pkt_q = '{0.5, 0.5};
      send_packet(1'b0, 1'b0);
      wait_idle();
      stale_mode = 1'b0;
      chk("stale_sum", 64'(Sum), 64'h3F800000);

      // Backpressure with changing data while not ready
      pkt_q = '{4.0, 5.0, 6.0};
      send_packet(1'b1, 1'b0);
      wait_idle();
      chk("bp_sum", 64'(Sum), 64'h41700000);
      chk("bp_count", 64'(SumCount), 64'(3));

      // Count saturation: 17 elements with a 4-bit counter
      pkt_q.delete();
      for (int i = 0; i < 17; i++) pkt_q.push_back(1.0);
      send_packet(1'b0, 1'b0);
      wait_idle();
      chk("sat_sum", 64'(Sum), 64'h41880000);
      chk("sat_count", 64'(SumCount), 64'(CNT_MAX));

      // Adder timeout
      hang_mode = 1'b1;
      pkt_q = '{1.0, 2.0};
      send_packet(1'b0, 1'b1);
      repeat (TIMEOUT + 1) @(negedge Clock);
      chk("timeout_error_before", 64'(Error), 64'(0));
      chk("timeout_ready_before", 64'(InReady), 64'(0));
      @(negedge Clock);
      chk("timeout_error", 64'(Error), 64'(1));
      chk("timeout_ready", 64'(InReady), 64'(1));
      chk("timeout_no_sum", 64'(SumValid), 64'(0));
      hang_mode = 1'b0;
      pkt_q = '{2.0};
      send_packet(1'b0, 1'b0);
      wait_idle();
      chk("after_timeout_sum", 64'(Sum), 64'h40000000);
      chk("error_sticky", 64'(Error), 64'(1));

      // Randomized packets
      for (int p = 0; p < 30; p++) begin
         int len;
         len = int'($urandom_range(1, 6));
         pkt_q.delete();
         for (int i = 0; i < len; i++) pkt_q.push_back(real'(int'($urandom_range(0, 200)) - 100));
         stale_mode = 1'($urandom);
         send_packet(1'($urandom), 1'b0);
      end
      wait_idle();
      stale_mode = 1'b0;

      // Asynchronous reset while waiting on the adder
      hang_mode = 1'b1;
      pkt_q = '{1.0, 2.0};
      send_packet(1'b0, 1'b1);
      repeat (3) @(negedge Clock);
      #2;
      Reset     = 1'b0;
      busy      = 1'b0;
      pend      = 1'b0;
      chk_on    = 1'b0;
      clr_cyc   = -1;
      hang_mode = 1'b0;
      #1;
      chk("arst_op1", 64'(Op1), 64'(0));
      chk("arst_op2", 64'(Op2), 64'(0));
      chk("arst_sum", 64'(Sum), 64'(0));
      chk("arst_sumcount", 64'(SumCount), 64'(0));
      chk("arst_addvalid", 64'(AddValid), 64'(0));
      chk("arst_sumvalid", 64'(SumValid), 64'(0));
      chk("arst_error", 64'(Error), 64'(0));
      @(negedge Clock);
      #2;
      Reset = 1'b1;
      @(negedge Clock);
      chk("arst_ready", 64'(InReady), 64'(1));
      AddResultValid = 1'b1;
      AddResult      = 32'h40400000;
      repeat (3) begin
         @(negedge Clock);
         chk("late_result_no_sum", 64'(SumValid), 64'(0));
         chk("late_result_no_add", 64'(AddValid), 64'(0));
      end
      AddResultValid = 1'b0;
      pkt_q = '{2.0, 3.0};
      send_packet(1'b0, 1'b0);
      wait_idle();
      chk("post_reset_sum", 64'(Sum), 64'h40A00000);

      chk("sums_outstanding", 64'(exp_sum_q.size()), 64'(0));
      chk("ops_outstanding", 64'(exp_op1_q.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
